// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit logical left shifter.
// Each operation is IDLE (grant/capture) -> SHIFT (register result) -> DONE (hold until consumed).
module shift_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic [2:0] req0_shamt,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic [2:0] req1_shamt,
    output logic       req1_ready,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_id,
    input  logic       res_ready,
    output logic [7:0] op_count
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SHAMT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                grant0;
    logic                grant1;
    logic                last_grant;
    logic [DATA_W-1:0]   cap_data;
    logic [SHAMT_W-1:0]  cap_shamt;
    logic                cap_id;
    logic [DATA_W-1:0]   shifted;

    // Next state and round-robin grant; a grant is only ever issued to a valid requester.
    always_comb begin
        state_nx = state;
        grant0   = 1'b0;
        grant1   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (req0_valid || req1_valid) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT:   state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Readies are forced low while reset is asserted.
    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;

    assign shifted = DATA_W'(cap_data << cap_shamt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand capture and last-grant pointer, both advanced only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            cap_data   <= '0;
            cap_shamt  <= '0;
            cap_id     <= 1'b0;
        end else if (grant0) begin
            last_grant <= 1'b0;
            cap_data   <= req0_data;
            cap_shamt  <= req0_shamt;
            cap_id     <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
            cap_data   <= req1_data;
            cap_shamt  <= req1_shamt;
            cap_id     <= 1'b1;
        end
    end

    // Result register: loaded in SHIFT, held through DONE until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            op_count  <= '0;
        end else if (state == SHIFT) begin
            res_valid <= 1'b1;
            res_data  <= shifted;
            res_id    <= cap_id;
        end else if (state == DONE && res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter: reset, latency, contention,
// backpressure, withdraw, fairness, mid-operation reset and counter wrap.
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic [2:0] req0_shamt;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic [2:0] req1_shamt;
    logic       req1_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       res_ready;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h12; req0_shamt = 3'd1;
        req1_valid = 1'b1; req1_data = 8'h34; req1_shamt = 3'd1;
        res_ready  = 1'b1;
        step();
        step();
        checks++;
        if (res_valid !== 1'b0 || res_data !== 8'h00 || res_id !== 1'b0 || op_count !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%h id=%b cnt=%0d, required 0/00/0/0",
                     res_valid, res_data, res_id, op_count);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_readies: r0=%b r1=%b, required 0 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_data = 8'h5A; req0_shamt = 3'd3;
        res_ready  = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_shift: r0=%b valid=%b, required 0 0", req0_ready, res_valid);
        end
        step();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'hD0 || res_id !== 1'b0) begin
            failures++;
            $display("FAIL single_result: valid=%b data=%h id=%b, required 1 d0 0",
                     res_valid, res_data, res_id);
        end
        step();
        checks++;
        if (res_valid !== 1'b0 || op_count !== 8'd1) begin
            failures++;
            $display("FAIL single_count: valid=%b cnt=%0d, required 0 1", res_valid, op_count);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h01; req0_shamt = 3'd7;
        req1_valid = 1'b1; req1_data = 8'hFF; req1_shamt = 3'd1;
        res_ready  = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL contend_first: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        step();
        checks++;
        if (res_data !== 8'h80 || res_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL contend_res0: data=%h id=%b r0=%b r1=%b, required 80 0 0 0",
                     res_data, res_id, req0_ready, req1_ready);
        end
        step();
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL contend_second: r0=%b r1=%b, required 0 1", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        step();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'hFE || res_id !== 1'b1) begin
            failures++;
            $display("FAIL contend_res1: valid=%b data=%h id=%b, required 1 fe 1",
                     res_valid, res_data, res_id);
        end
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] cnt0;
        cnt0 = op_count;
        req1_valid = 1'b1; req1_data = 8'h81; req1_shamt = 3'd4;
        res_ready  = 1'b0;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h07; req0_shamt = 3'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== 8'h10 || res_id !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || op_count !== cnt0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h id=%b r0=%b r1=%b cnt=%0d, required 1 10 1 0 0 %0d",
                         i, res_valid, res_data, res_id, req0_ready, req1_ready, op_count, cnt0);
            end
            step();
        end
        res_ready = 1'b1;
        step();
        checks++;
        if (res_valid !== 1'b0 || req0_ready !== 1'b1 || op_count !== cnt0 + 8'd1) begin
            failures++;
            $display("FAIL stall_release: valid=%b r0=%b cnt=%0d, required 0 1 %0d",
                     res_valid, req0_ready, op_count, cnt0 + 8'd1);
        end
        // Take the pending req0 operation (shamt 0 returns data unchanged).
        step();
        req0_valid = 1'b0;
        step();
        checks++;
        if (res_data !== 8'h07 || res_id !== 1'b0) begin
            failures++;
            $display("FAIL shamt_zero: data=%h id=%b, required 07 0", res_data, res_id);
        end
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_withdraw();
        logic [7:0] cnt0;
        cnt0 = op_count;
        req1_valid = 1'b1; req1_data = 8'h55; req1_shamt = 3'd2;
        #1;
        req1_valid = 1'b0;
        step();
        step();
        checks++;
        if (res_valid !== 1'b0 || op_count !== cnt0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL withdraw: valid=%b cnt=%0d r1=%b, required 0 %0d 0",
                     res_valid, op_count, req1_ready, cnt0);
        end
    endtask

    task automatic test_fairness();
        logic exp_id;
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h03; req0_shamt = 3'd1;
        req1_valid = 1'b1; req1_data = 8'h11; req1_shamt = 3'd2;
        res_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_id = 1'(i % 2);
            #1;
            checks++;
            if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
                failures++;
                $display("FAIL fair_grant[%0d]: r0=%b r1=%b, required %b %b",
                         i, req0_ready, req1_ready, ~exp_id, exp_id);
            end
            step();
            step();
            checks++;
            if (res_id !== exp_id || res_data !== (exp_id ? 8'h44 : 8'h06)) begin
                failures++;
                $display("FAIL fair_result[%0d]: id=%b data=%h, required %b %h",
                         i, res_id, res_data, exp_id, exp_id ? 8'h44 : 8'h06);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (op_count !== 8'd6) begin
            failures++;
            $display("FAIL fair_count: cnt=%0d, required 6", op_count);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h0F; req0_shamt = 3'd2;
        res_ready  = 1'b1;
        step();
        req0_valid = 1'b0;
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_data = 8'h22; req1_shamt = 3'd1;
        step();
        step();
        checks++;
        if (res_valid !== 1'b0 || op_count !== 8'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b cnt=%0d r0=%b r1=%b, required 0 0 0 0",
                     res_valid, op_count, req0_ready, req1_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_regrant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h3C || res_id !== 1'b0) begin
            failures++;
            $display("FAIL mid_result: valid=%b data=%h id=%b, required 1 3c 0",
                     res_valid, res_data, res_id);
        end
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        req0_data  = 8'h80;
        req0_shamt = 3'd1;
        res_ready  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            req0_valid = 1'b1;
            step();
            req0_valid = 1'b0;
            step();
            if (i == 0) begin
                checks++;
                if (res_data !== 8'h00 || res_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_discard: data=%h valid=%b, required 00 1", res_data, res_valid);
                end
            end
            step();
            if (i == 254) begin
                checks++;
                if (op_count !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_255: cnt=%0d, required 255", op_count);
                end
            end
        end
        checks++;
        if (op_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_count: cnt=%0d, required 0", op_count);
        end
        res_ready = 1'b0;
    endtask

    // Readies must never both be high.
    always @(negedge clk) begin
        if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_onehot: r0=%b r1=%b, required not both 1", req0_ready, req1_ready);
        end
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req0_shamt = 3'd0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_shamt = 3'd0;
        res_ready  = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_withdraw();
        test_fairness();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
